// File: rtl/multi_width_packer_if.sv
// ---------------------------------------------------------------------------
// multi_width_packer_if
// Bus bundle between a beat producer/consumer and multi_width_packer.
//   master : drives tracing, valid_in, eof_in, chainId_in, configId,
//            configData, vector_in, out_ready; samples in_ready,
//            vector_out, count_out, valid_out.
//   slave  : the packer itself (directions mirrored).
// Vectors are packed as [element][bit]; element 0 is the first/oldest.
// ---------------------------------------------------------------------------
interface multi_width_packer_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4
);
  localparam int CHW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;

  logic                              tracing;
  logic                              valid_in;
  logic                              in_ready;
  logic                              eof_in;
  logic [CHW-1:0]                    chainId_in;
  logic [7:0]                        configId;
  logic [7:0]                        configData;
  logic [N-1:0][DATA_WIDTH-1:0]      vector_in;
  logic [N-1:0][DATA_WIDTH-1:0]      vector_out;
  logic [$clog2(N):0]                count_out;
  logic                              valid_out;
  logic                              out_ready;

  modport master (
    output tracing, valid_in, eof_in, chainId_in, configId, configData,
           vector_in, out_ready,
    input  in_ready, vector_out, count_out, valid_out
  );

  modport slave (
    input  tracing, valid_in, eof_in, chainId_in, configId, configData,
           vector_in, out_ready,
    output in_ready, vector_out, count_out, valid_out
  );
endinterface

// File: rtl/multi_width_packer.sv
// ---------------------------------------------------------------------------
// multi_width_packer
// Collects variable-length beats (L = 1 << len_code, code 0 = full length N)
// per chain into an N-element buffer and emits a packed vector whenever the
// buffer fills or would overflow. Output is registered with a valid/ready
// handshake. In configuration mode (tracing=0) a byte stream addressed by
// configId loads len_code per chain, then flush_en per chain.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : multi_width_packer_if.slave (beat input, config, packed out)
// Optional feature macro: PACKER_FLUSH_EN -- eof_in on a chain with
// flush_en set forces emission of the partial buffer (with a one-cycle
// PEND state when the eof beat itself overflows).
// ---------------------------------------------------------------------------
module multi_width_packer #(
  parameter int N                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_CHAINS         = 4,
  parameter int PERSONAL_CONFIG_ID = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_width_packer_if.slave   bus
);
  localparam int LOGN = $clog2(N);
  localparam int CNTW = LOGN + 1;
  localparam int SUMW = LOGN + 2;
  localparam int CHW  = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
  localparam int BCW  = $clog2(2 * MAX_CHAINS + 1);

  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;
  typedef enum logic {ACCUM = 1'b0, PEND = 1'b1} state_t;

  state_t           state, nxt_state;
  logic [CNTW-1:0]  cnt, nxt_cnt;
  vec_t             buffer, nxt_buf;
  logic [7:0]       len_code [MAX_CHAINS];
  logic [BCW-1:0]   byte_counter;

  logic [7:0]       cur_code;
  logic             len_ok;
  logic             accept;
  logic             flush;
  logic             slot_free;
  logic [CNTW-1:0]  beat_len;
  logic [SUMW-1:0]  sum;
  vec_t             merged;
  logic             emit_vld_p0;
  vec_t             emit_vec_p0;
  logic [CNTW-1:0]  emit_cnt_p0;

  // ---- stage p0: beat decode, merge and emission decision ----
  assign cur_code  = len_code[bus.chainId_in];
  assign len_ok    = (cur_code <= 8'(LOGN));
  assign beat_len  = (cur_code == 8'd0) ? CNTW'(N) : (CNTW'(1) << cur_code);
  assign slot_free = !bus.valid_out || bus.out_ready;
  assign accept    = bus.valid_in && bus.tracing && bus.in_ready && len_ok;
  assign sum       = SUMW'(cnt) + SUMW'(beat_len);

`ifdef PACKER_FLUSH_EN
  logic [MAX_CHAINS-1:0] flush_en;
  assign flush = accept && bus.eof_in && flush_en[bus.chainId_in];
`else
  logic unused_eof;
  assign unused_eof = bus.eof_in;
  assign flush      = 1'b0;
`endif

  // Buffer slots above cnt are always zero, so the old buffer can be emitted
  // directly on overflow without masking.
  always_comb begin
    merged = buffer;
    for (int j = 0; j < N; j++) begin
      if (j >= int'(cnt) && j < int'(sum))
        merged[j] = bus.vector_in[LOGN'(j - int'(cnt))];
    end
  end

  // next-state / datapath next values
  always_comb begin
    nxt_state   = state;
    nxt_cnt     = cnt;
    nxt_buf     = buffer;
    emit_vld_p0 = 1'b0;
    emit_vec_p0 = '0;
    emit_cnt_p0 = '0;
    case (state)
      ACCUM: begin
        if (accept) begin
          if (sum > SUMW'(N)) begin
            // overflow: ship what is held, the beat starts a fresh buffer
            emit_vld_p0 = 1'b1;
            emit_vec_p0 = buffer;
            emit_cnt_p0 = cnt;
            nxt_cnt     = beat_len;
            nxt_buf     = '0;
            for (int j = 0; j < N; j++) begin
              if (j < int'(beat_len)) nxt_buf[j] = bus.vector_in[j];
            end
            if (flush) nxt_state = PEND;
          end else if (sum == SUMW'(N) || flush) begin
            emit_vld_p0 = 1'b1;
            emit_vec_p0 = merged;
            emit_cnt_p0 = CNTW'(sum);
            nxt_cnt     = '0;
            nxt_buf     = '0;
          end else begin
            nxt_buf = merged;
            nxt_cnt = CNTW'(sum);
          end
        end
      end
      PEND: begin
        // drain the eof beat parked by an overflowing flush
        if (slot_free) begin
          emit_vld_p0 = 1'b1;
          emit_vec_p0 = buffer;
          emit_cnt_p0 = cnt;
          nxt_cnt     = '0;
          nxt_buf     = '0;
          nxt_state   = ACCUM;
        end
      end
      default: nxt_state = ACCUM;
    endcase
  end

  // FSM output
  always_comb begin
    bus.in_ready = slot_free && (state == ACCUM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= nxt_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      buffer <= '0;
    end else begin
      cnt    <= nxt_cnt;
      buffer <= nxt_buf;
    end
  end

  // ---- stage p1: registered output with hold under backpressure ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.valid_out  <= 1'b0;
      bus.vector_out <= '0;
      bus.count_out  <= '0;
    end else if (emit_vld_p0) begin
      bus.valid_out  <= 1'b1;
      bus.vector_out <= emit_vec_p0;
      bus.count_out  <= emit_cnt_p0;
    end else if (bus.valid_out && bus.out_ready) begin
      bus.valid_out  <= 1'b0;
    end
  end

  // Configuration byte stream; the counter saturates so trailing bytes
  // are dropped instead of wrapping onto len_code again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_counter <= '0;
      for (int c = 0; c < MAX_CHAINS; c++) len_code[c] <= 8'd0;
`ifdef PACKER_FLUSH_EN
      flush_en <= '0;
`endif
    end else if (!bus.tracing) begin
      if (bus.configId == 8'(PERSONAL_CONFIG_ID)) begin
        if (byte_counter < BCW'(MAX_CHAINS))
          len_code[byte_counter[CHW-1:0]] <= bus.configData;
`ifdef PACKER_FLUSH_EN
        else if (byte_counter < BCW'(2 * MAX_CHAINS))
          flush_en[CHW'(byte_counter - BCW'(MAX_CHAINS))] <= bus.configData[0];
`endif
        if (byte_counter < BCW'(2 * MAX_CHAINS))
          byte_counter <= byte_counter + BCW'(1);
      end else begin
        byte_counter <= '0;
      end
    end
  end
endmodule
